// File: rtl/uart_ctrl_top_if.sv
// Pin-side bundle of the UART controller: button, serial lines, tx byte and status.
// slave  : the controller (reads btn_start/rx/tx_din, drives everything else).
// master : board/user side that drives the requests and watches the status.
`timescale 1ns/1ps
interface uart_ctrl_top_if;
  logic       btn_start;  // transmit request level, asynchronous
  logic       rx;         // serial receive line, idle high
  logic [7:0] tx_din;     // byte captured when a request is accepted
  logic       tx_busy;    // frame in progress on tx
  logic [7:0] rx_data;    // last good received byte
  logic       rx_done;    // 1-clk pulse per good frame
  logic       tx_done;    // 1-clk pulse at end of tx stop bit
  logic       tx;         // serial transmit line, idle high

  modport slave (
    input  btn_start, rx, tx_din,
    output tx_busy, rx_data, rx_done, tx_done, tx
  );
  modport master (
    output btn_start, rx, tx_din,
    input  tx_busy, rx_data, rx_done, tx_done, tx
  );
endinterface

// File: rtl/uart_ctrl_top.sv
// Full-duplex 8N1 UART: shared oversample tick, button-triggered TX, RX with false-start/framing rejection.
// Latency: TX start bit begins at the first tick after a request is accepted; rx_done fires mid stop bit.
// Backpressure: requests arriving while TX is not idle are dropped; no flow control on rx.
// Optional: `define UART_ECHO_EN to add a 1-byte echo buffer that retransmits each good rx byte.
// Ports: clk, rst (async active-low); uart (slave modport): btn_start, rx, tx_din in;
//        tx_busy, rx_data, rx_done, tx_done, tx out.
`timescale 1ns/1ps
module uart_ctrl_top #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_ctrl_top_if.slave uart
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);

  // ---------------- shared tick ----------------
  logic [CW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + CW'(1);
  end

  // ---------------- input synchronizers ----------------
  logic r_btn_m, r_btn_s, r_btn_d;
  logic r_rx_m, r_rx_s;
  logic w_btn_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_m <= 1'b0;
      r_btn_s <= 1'b0;
      r_btn_d <= 1'b0;
      r_rx_m  <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_btn_m <= uart.btn_start;
      r_btn_s <= r_btn_m;
      r_btn_d <= r_btn_s;
      r_rx_m  <= uart.rx;
      r_rx_s  <= r_rx_m;
    end
  end

  assign w_btn_rise = r_btn_s & ~r_btn_d;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      r_rx_state, w_rx_state_nxt;
  logic [OSW-1:0] r_rx_tick, w_rx_tick_nxt;
  logic [2:0]     r_rx_bit, w_rx_bit_nxt;
  logic [7:0]     r_rx_shift, w_rx_shift_nxt;
  logic [7:0]     r_rx_data, w_rx_data_nxt;
  logic           r_rx_wait, w_rx_wait_nxt;  // bad stop bit seen, waiting for line to go idle
  logic           r_rx_done, w_rx_done_nxt;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tick_nxt  = r_rx_tick;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_wait_nxt  = r_rx_wait;
    w_rx_done_nxt  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_s) begin
          w_rx_state_nxt = RX_START;
          w_rx_tick_nxt  = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_tick == OS_MID) begin
            // Mid start bit: a high line here means the low was a glitch.
            w_rx_tick_nxt = '0;
            w_rx_bit_nxt  = '0;
            w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_tick_nxt = r_rx_tick + OSW'(1);
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_tick == OS_LAST) begin
            w_rx_tick_nxt  = '0;
            w_rx_shift_nxt = {r_rx_s, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
          end else begin
            w_rx_tick_nxt = r_rx_tick + OSW'(1);
          end
        end
      end
      RX_STOP: begin
        if (r_rx_wait) begin
          if (r_rx_s) begin
            w_rx_wait_nxt  = 1'b0;
            w_rx_state_nxt = RX_IDLE;
          end
        end else if (w_tick) begin
          if (r_rx_tick == OS_LAST) begin
            w_rx_tick_nxt = '0;
            if (r_rx_s) begin
              w_rx_data_nxt  = r_rx_shift;
              w_rx_done_nxt  = 1'b1;
              w_rx_state_nxt = RX_IDLE;
            end else begin
              w_rx_wait_nxt = 1'b1;
            end
          end else begin
            w_rx_tick_nxt = r_rx_tick + OSW'(1);
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_wait  <= 1'b0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_tick  <= w_rx_tick_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_wait  <= w_rx_wait_nxt;
      r_rx_done  <= w_rx_done_nxt;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t      r_tx_state, w_tx_state_nxt;
  logic           r_tx_arm, w_tx_arm_nxt;   // byte latched, waiting for the next tick to start
  logic [OSW-1:0] r_tx_tick, w_tx_tick_nxt;
  logic [2:0]     r_tx_bit, w_tx_bit_nxt;
  logic [7:0]     r_tx_shift, w_tx_shift_nxt;
  logic           r_tx, w_tx_nxt;
  logic           r_tx_busy, w_tx_busy_nxt;
  logic           r_tx_done, w_tx_done_nxt;
  logic           w_tx_free;
  logic           w_tx_load;
  logic [7:0]     w_tx_load_dat;

  assign w_tx_free = (r_tx_state == TX_IDLE) && !r_tx_arm;

`ifdef UART_ECHO_EN
  logic       r_echo_pend;
  logic [7:0] r_echo_dat;
  logic       w_echo_take;

  assign w_echo_take = w_tx_free & r_echo_pend;

  // A fresh rx byte wins over the clear, so an overlapping take still leaves the new byte pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_echo_pend <= 1'b0;
      r_echo_dat  <= '0;
    end else if (r_rx_done) begin
      r_echo_pend <= 1'b1;
      r_echo_dat  <= r_rx_data;
    end else if (w_echo_take) begin
      r_echo_pend <= 1'b0;
    end
  end

  // Echo has priority; a button edge in the same cycle is dropped.
  assign w_tx_load     = w_tx_free & (r_echo_pend | w_btn_rise);
  assign w_tx_load_dat = r_echo_pend ? r_echo_dat : uart.tx_din;
`else
  assign w_tx_load     = w_tx_free & w_btn_rise;
  assign w_tx_load_dat = uart.tx_din;
`endif

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_arm_nxt   = r_tx_arm;
    w_tx_tick_nxt  = r_tx_tick;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_done_nxt  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_load) begin
          w_tx_arm_nxt   = 1'b1;
          w_tx_busy_nxt  = 1'b1;
          w_tx_shift_nxt = w_tx_load_dat;
        end else if (r_tx_arm && w_tick) begin
          w_tx_arm_nxt   = 1'b0;
          w_tx_state_nxt = TX_START;
          w_tx_tick_nxt  = '0;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_START: begin
        if (w_tick) begin
          if (r_tx_tick == OS_LAST) begin
            w_tx_tick_nxt  = '0;
            w_tx_bit_nxt   = '0;
            w_tx_state_nxt = TX_DATA;
            w_tx_nxt       = r_tx_shift[0];
          end else begin
            w_tx_tick_nxt = r_tx_tick + OSW'(1);
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_tick == OS_LAST) begin
            w_tx_tick_nxt = '0;
            if (r_tx_bit == 3'd7) begin
              w_tx_state_nxt = TX_STOP;
              w_tx_nxt       = 1'b1;
            end else begin
              w_tx_bit_nxt   = r_tx_bit + 3'd1;
              w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
              w_tx_nxt       = r_tx_shift[1];
            end
          end else begin
            w_tx_tick_nxt = r_tx_tick + OSW'(1);
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_tick == OS_LAST) begin
            w_tx_tick_nxt  = '0;
            w_tx_state_nxt = TX_IDLE;
            w_tx_busy_nxt  = 1'b0;
            w_tx_done_nxt  = 1'b1;
          end else begin
            w_tx_tick_nxt = r_tx_tick + OSW'(1);
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_arm   <= 1'b0;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_arm   <= w_tx_arm_nxt;
      r_tx_tick  <= w_tx_tick_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
      r_tx_done  <= w_tx_done_nxt;
    end
  end

  assign uart.tx      = r_tx;
  assign uart.tx_busy = r_tx_busy;
  assign uart.tx_done = r_tx_done;
  assign uart.rx_data = r_rx_data;
  assign uart.rx_done = r_rx_done;

endmodule

// File: tb/tb_uart_ctrl_top.sv
// Scoreboard bench for uart_ctrl_top, run with a tick divisor of 4 (one bit = 64 clk).
// Stimulus pushes expected tx bytes / rx bytes into queues; monitors decode tx and watch rx_done.
`timescale 1ns/1ps
module tb_uart_ctrl_top;
  localparam int CLK_FREQ = 640_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = 64;   // 640000/(10000*16) = 4 clk per tick, 16 ticks per bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_ctrl_top_if bus();

  uart_ctrl_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk  (clk),
    .rst  (rst),
    .uart (bus)
  );

  int checks = 0;
  int errors = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int exp_frames = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic prev_tx_done = 1'b0;
  logic prev_rx_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus.tx_done) begin
      tx_done_cnt++;
      check("tx_done_width", prev_tx_done, 1'b0);
      check("tx_busy_at_done", bus.tx_busy, 1'b0);
    end
    prev_tx_done = bus.tx_done;
  end

  always @(negedge clk) begin
    if (rst && bus.rx_done) begin
      rx_done_cnt++;
      check("rx_done_width", prev_rx_done, 1'b0);
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got byte %02h expected no rx_done", bus.rx_data);
      end else begin
        check("rx_data", bus.rx_data, exp_rx_q.pop_front());
      end
    end
    prev_rx_done = bus.rx_done;
  end

  task automatic wait_clk_rst(input int n, inout bit alive);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) alive = 1'b0;
    end
  endtask

  task automatic decode_frame();
    bit alive = 1'b1;
    logic [7:0] b = '0;
    logic s_start, s_stop, busy_mid;
    wait_clk_rst(BIT / 2, alive); #1;
    s_start  = bus.tx;
    busy_mid = bus.tx_busy;
    for (int i = 0; i < 8; i++) begin
      wait_clk_rst(BIT, alive); #1;
      b[i] = bus.tx;
    end
    wait_clk_rst(BIT, alive); #1;
    s_stop = bus.tx;
    if (alive && rst) begin
      check("tx_start_bit", s_start, 1'b0);
      check("tx_busy_in_frame", busy_mid, 1'b1);
      check("tx_stop_bit", s_stop, 1'b1);
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got frame %02h expected no frame", b);
      end else begin
        check("tx_byte", b, exp_tx_q.pop_front());
      end
    end
  endtask

  initial begin : tx_mon
    forever begin
      @(negedge bus.tx);
      if (rst) decode_frame();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic wait_tx_done(input int target, input string name);
    int n = 0;
    while (tx_done_cnt < target && n < 14 * BIT) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_done_cnt, target);
  endtask

  task automatic expect_rx(input logic [7:0] b);
    exp_rx_q.push_back(b);
`ifdef UART_ECHO_EN
    exp_tx_q.push_back(b);
    exp_frames++;
`endif
  endtask

  initial begin : watchdog
    #(60_000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 clk");
    $fatal(1, "watchdog");
  end

  logic [7:0] vec [8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hE7};

  initial begin : stim
    int n;
    bus.btn_start = 1'b0;
    bus.rx        = 1'b1;
    bus.tx_din    = 8'h00;

    // Reset
    #1 rst = 1'b0;
    #20 rst = 1'b1;
    @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_tx_busy", bus.tx_busy, 1'b0);
    check("rst_rx_done", bus.rx_done, 1'b0);
    check("rst_tx_done", bus.tx_done, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);

    // Button transmit of A5, button held well past the frame
    repeat (10) @(negedge clk);
    bus.tx_din = 8'hA5;
    exp_tx_q.push_back(8'hA5);
    exp_frames++;
    bus.btn_start = 1'b1;
    n = 0;
    while (bus.tx !== 1'b0 && n < 2 * BIT) begin @(posedge clk); #1; n++; end
    check("tx_start_seen", bus.tx, 1'b0);
    n = 0;
    while (bus.tx === 1'b0 && n < 2 * BIT) begin @(posedge clk); #1; n++; end
    check("tx_start_len", n, BIT);
    repeat (13 * BIT) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("tx_one_frame", tx_done_cnt, exp_frames);

    // Receive 31 (echoed when the echo buffer is built in)
    expect_rx(8'h31);
    send_byte(8'h31, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("rx_count_31", rx_done_cnt, 1);
    check("rx_data_31", bus.rx_data, 8'h31);
    wait_tx_done(exp_frames, "echo_31_done");

    // Glitch on rx
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_no_rx_done", rx_done_cnt, 1);

    // Framing error: 5A with stop held low
    send_byte(8'h5A, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("frame_err_no_rx_done", rx_done_cnt, 1);
    check("frame_err_rx_data_hold", bus.rx_data, 8'h31);

    // Simultaneous tx (C3 by button) and rx (7E)
    bus.tx_din = 8'hC3;
    exp_tx_q.push_back(8'hC3);
    exp_frames++;
    expect_rx(8'h7E);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        bus.btn_start = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_start = 1'b0;
      end
    join
    wait_tx_done(exp_frames, "duplex_tx_done");
    check("duplex_rx_data", bus.rx_data, 8'h7E);

    // Byte table received back to back with a 2-bit gap
    foreach (vec[i]) begin
      expect_rx(vec[i]);
      send_byte(vec[i], 1'b1);
      repeat (2 * BIT) @(negedge clk);
    end
    check("table_rx_count", rx_done_cnt, 10);
    wait_tx_done(exp_frames, "table_tx_done");

    // Reset in the middle of a tx frame (F0 keeps tx low through bit 3)
    bus.tx_din = 8'hF0;
    bus.btn_start = 1'b1;
    repeat (5) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("pre_rst_tx_low", bus.tx, 1'b0);
    rst = 1'b0;
    #1;
    check("midframe_rst_tx", bus.tx, 1'b1);
    check("midframe_rst_busy", bus.tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("post_rst_tx_idle", bus.tx, 1'b1);
    check("post_rst_busy_idle", bus.tx_busy, 1'b0);

    // Final scoreboard state
    check("tx_queue_empty", exp_tx_q.size(), 0);
    check("rx_queue_empty", exp_rx_q.size(), 0);
    check("tx_done_total", tx_done_cnt, exp_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
